mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store FIFO, STATUS register, sticky overflow flag.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits (11-bit frames).
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      shift_q;

    logic            empty, full, push, pop;
    logic            store_tx, store_status;
    logic            unused_data;

    assign empty        = (count_q == '0);
    assign full         = (count_q == COUNT_FULL);
    assign store_tx     = we_i & ~addr_i;
    assign store_status = we_i & addr_i;
    // A pop in the same cycle frees a slot, so a store to a full FIFO still lands.
    assign push         = store_tx & (~full | pop);
    assign busy_o       = (state_q != S_IDLE) | ~empty;
    assign data_o       = addr_i ? {28'b0, ovf_q, busy_o, full, empty} : 32'h0;
    assign unused_data  = |data_i[31:8];

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        tx_o    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = BAUD_RELOAD;
                end
            end
            S_START: begin
                tx_o = 1'b0;
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                tx_o = shift_q[bit_q];
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_o = ^shift_q;
                if (baud_q == '0) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
`endif
            S_STOP: begin
                tx_o = 1'b1;
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        baud_d  = BAUD_RELOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (store_status) begin
            ovf_d = 1'b0;
        end else if (store_tx && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage carries no reset; control state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data_i[7:0];
        end
        if (pop) begin
            shift_q <= mem_q[rptr_q];
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level reference model plus directed literal checks.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        addr_i;
    logic        we_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_mis = 0;
    bit check_en = 1'b0;

    byte unsigned m_q[$];
    logic [7:0]   m_cur;
    bit           m_act = 1'b0;
    bit           m_ovf = 1'b0;
    int           m_pos = 0;

    logic s_tx   [0:99];
    logic s_busy [0:99];

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .we_i    (we_i),
        .data_o  (data_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit k of a serial frame: start, 8 data LSB first, optional parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Reference model: a byte queue and a position counter over the whole frame.
    initial begin
        forever begin
            @(posedge clk or negedge reset_i);
            if (!reset_i) begin
                m_q.delete();
                m_act = 1'b0;
                m_pos = 0;
                m_ovf = 1'b0;
            end else begin
                int sz;
                bit endf;
                bit pp;
                sz   = m_q.size();
                endf = m_act && (m_pos == FRAME_CYC - 1);
                pp   = (sz > 0) && (!m_act || endf);
                if (pp) begin
                    m_cur = m_q.pop_front();
                    m_act = 1'b1;
                    m_pos = 0;
                end else if (endf) begin
                    m_act = 1'b0;
                end else if (m_act) begin
                    m_pos++;
                end
                if (we_i && !addr_i) begin
                    if (sz < DEPTH || pp) m_q.push_back(data_i[7:0]);
                    else m_ovf = 1'b1;
                end
                if (we_i && addr_i) m_ovf = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                logic        e_busy;
                logic        e_tx;
                logic [31:0] e_st;
                e_busy = m_act || (m_q.size() != 0);
                e_tx   = m_act ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
                e_st   = {28'b0, m_ovf, e_busy, m_q.size() == DEPTH, m_q.size() == 0};
                chk("model_tx", 32'(tx_o), 32'(e_tx));
                chk("model_busy", 32'(busy_o), 32'(e_busy));
                chk("model_data_o", data_o, addr_i ? e_st : 32'h0);
            end
        end
    end

    task automatic do_write(input logic a, input logic [31:0] d);
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(posedge clk);
        #1;
        we_i   = 1'b0;
        addr_i = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_tx[i]   = tx_o;
            s_busy[i] = busy_o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        while (busy_o && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("idle_timeout", 32'(busy_o), 32'h0);
    endtask

    initial begin
        logic [9:0] exp55;
        logic       any_low;
        exp55   = 10'b1010101010;
        reset_i = 1'b0;
        we_i    = 1'b0;
        addr_i  = 1'b1;
        data_i  = 32'h0;
        #1 check_en = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_o), 32'h1);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_status", data_o, 32'h1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_status", data_o, 32'h1);
        addr_i = 1'b0;
        #1;
        chk("txdata_read_zero", data_o, 32'h0);

        // Single byte 0x55
        do_write(1'b0, 32'hFFFF_FF55);
        capture(FRAME_CYC + 4);
        chk("b55_queued_busy", 32'(s_busy[0]), 32'h1);
        for (int i = 0; i < 36; i++) chk("b55_bit", 32'(s_tx[i+1]), 32'(exp55[i/CPB]));
        chk("b55_stop", 32'(s_tx[FRAME_CYC]), 32'h1);
        chk("b55_busy_last", 32'(s_busy[FRAME_CYC]), 32'h1);
        chk("b55_busy_done", 32'(s_busy[FRAME_CYC+1]), 32'h0);

        // Back-to-back 0x01 then 0x80
        wait_idle(200);
        do_write(1'b0, 32'h01);
        do_write(1'b0, 32'h80);
        capture(2 * FRAME_CYC + 4);
        chk("b2b_start1", 32'(s_tx[0]), 32'h0);
        chk("b2b_d0_first", 32'(s_tx[4]), 32'h1);
        chk("b2b_d1_first", 32'(s_tx[8]), 32'h0);
        chk("b2b_stop1", 32'(s_tx[FRAME_CYC-1]), 32'h1);
        chk("b2b_start2_nogap", 32'(s_tx[FRAME_CYC]), 32'h0);
        chk("b2b_busy_gap", 32'(s_busy[FRAME_CYC]), 32'h1);
        chk("b2b_d6_second", 32'(s_tx[FRAME_CYC+28]), 32'h0);
        chk("b2b_d7_second", 32'(s_tx[FRAME_CYC+32]), 32'h1);
        chk("b2b_busy_last", 32'(s_busy[2*FRAME_CYC-1]), 32'h1);
        chk("b2b_busy_done", 32'(s_busy[2*FRAME_CYC]), 32'h0);

        // Overflow: one popped, four queued, sixth dropped
        wait_idle(200);
        for (int k = 0; k < 6; k++) do_write(1'b0, 32'h10 + k);
        addr_i = 1'b1;
        #1;
        chk("ovf_set", 32'(data_o[3]), 32'h1);
        chk("ovf_full", 32'(data_o[1]), 32'h1);
        do_write(1'b1, 32'hFFFF_FFFF);
        addr_i = 1'b1;
        #1;
        chk("ovf_cleared", 32'(data_o[3]), 32'h0);
        chk("ovf_still_full", 32'(data_o[1]), 32'h1);
        addr_i = 1'b0;
        wait_idle(6 * FRAME_CYC);

        // Reset during DATA bit 3
        do_write(1'b0, 32'hA5);
        repeat (17) @(posedge clk);
        #2;
        reset_i = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_o), 32'h1);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        addr_i = 1'b1;
        #1;
        chk("midrst_status", data_o, 32'h1);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        chk("midrst_status_rel", data_o, 32'h1);
        capture(60);
        any_low = 1'b0;
        for (int i = 0; i < 60; i++) any_low = any_low | ~s_tx[i] | s_busy[i];
        chk("midrst_no_frame", 32'(any_low), 32'h0);

`ifdef UART_TX_PARITY_EN
        addr_i = 1'b0;
        do_write(1'b0, 32'h07);
        capture(FRAME_CYC + 4);
        chk("par_d2", 32'(s_tx[13]), 32'h1);
        chk("par_d3", 32'(s_tx[17]), 32'h0);
        chk("par_bit", 32'(s_tx[37]), 32'h1);
        chk("par_stop", 32'(s_tx[41]), 32'h1);
        chk("par_busy_last", 32'(s_busy[44]), 32'h1);
        chk("par_busy_done", 32'(s_busy[45]), 32'h0);
`endif

        // Randomized traffic in alternating dense/sparse phases with rare resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (((cyc / 500) % 2) == 0) we_i = ($urandom_range(0, 5) == 0);
            else we_i = ($urandom_range(0, 59) == 0);
            addr_i  = ($urandom_range(0, 7) == 0);
            data_i  = $urandom;
            reset_i = ($urandom_range(0, 999) != 0);
            @(posedge clk);
            #1;
        end
        we_i    = 1'b0;
        addr_i  = 1'b1;
        reset_i = 1'b1;
        wait_idle(8 * FRAME_CYC);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
